// File: rtl/ddr3_init_seq.sv
// DDR3 power-up/initialisation sequencer with periodic refresh scheduling.
// Latency: reset, CKE, MRS, ZQCL and refresh spacing set by the T_* parameters (clock cycles).
// Backpressure: none on the DRAM side; refreshes queue (up to 8) until the controller grants ref_ack.
//
// Ports:
//   clock, reset      - sole clock, synchronous active-high reset
//   start             - one-cycle pulse, honoured only in PWR_IDLE
//   ref_ack           - controller grants a refresh slot (honoured in READY with work pending)
//   rst_n, cke        - DRAM RESET# and CKE
//   cs_n, cmd, ba,    - DRAM command bus; cmd = {ras_n, cas_n, we_n}; NOP whenever no command issues
//   addr
//   busy, done        - sequencer owns the bus / initialisation complete (sticky until reset)
//   ref_req,          - at least one / eight refreshes pending
//   ref_urgent
//
// Build option: define DDR3_INIT_SEQ_ZQ_EN to run ZQCL calibration after each rank's MR0.
module ddr3_init_seq #(
  parameter int          RANKS    = 1,
  parameter int          T_RESET  = 200,
  parameter int          T_CKE    = 500,
  parameter int          T_XPR    = 120,
  parameter int          T_MRD    = 4,
  parameter int          T_MOD    = 12,
  parameter int          T_ZQINIT = 512,
  parameter int          T_REFI   = 7800,
  parameter int          T_RFC    = 110,
  parameter logic [15:0] MR0_VAL  = 16'h0000,
  parameter logic [15:0] MR1_VAL  = 16'h0000,
  parameter logic [15:0] MR2_VAL  = 16'h0000,
  parameter logic [15:0] MR3_VAL  = 16'h0000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             ref_ack,
  output logic             rst_n,
  output logic             cke,
  output logic [RANKS-1:0] cs_n,
  output logic [2:0]       cmd,
  output logic [2:0]       ba,
  output logic [15:0]      addr,
  output logic             busy,
  output logic             done,
  output logic             ref_req,
  output logic             ref_urgent
);

  // One counter width covers every timed phase, including the refresh interval.
  localparam int MAX_A = (T_RESET > T_CKE)    ? T_RESET : T_CKE;
  localparam int MAX_B = (T_XPR   > T_MRD)    ? T_XPR   : T_MRD;
  localparam int MAX_C = (T_MOD   > T_ZQINIT) ? T_MOD   : T_ZQINIT;
  localparam int MAX_D = (T_REFI  > T_RFC)    ? T_REFI  : T_RFC;
  localparam int MAX_E = (MAX_A   > MAX_B)    ? MAX_A   : MAX_B;
  localparam int MAX_F = (MAX_C   > MAX_D)    ? MAX_C   : MAX_D;
  localparam int MAX_T = (MAX_E   > MAX_F)    ? MAX_E   : MAX_F;
  localparam int CW    = $clog2(MAX_T + 1);
  localparam int RW    = (RANKS > 1) ? $clog2(RANKS) : 1;

  // Terminal counts: a phase of N cycles ends when the counter shows N-1.
  localparam logic [CW-1:0] RESET_END = CW'(T_RESET - 1);
  localparam logic [CW-1:0] CKE_END   = CW'(T_CKE - 1);
  localparam logic [CW-1:0] XPR_END   = CW'(T_XPR - 1);
  localparam logic [CW-1:0] MRD_END   = CW'(T_MRD - 1);
  localparam logic [CW-1:0] MOD_END   = CW'(T_MOD - 1);
`ifdef DDR3_INIT_SEQ_ZQ_EN
  localparam logic [CW-1:0] ZQI_END   = CW'(T_ZQINIT - 1);
`endif
  localparam logic [CW-1:0] REFI_END  = CW'(T_REFI - 1);
  localparam logic [CW-1:0] RFC_END   = CW'(T_RFC - 1);
  localparam logic [RW-1:0] LAST_RANK = RW'(RANKS - 1);

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_MRS = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_ZQ  = 3'b110;

  typedef enum logic [3:0] {
    PWR_IDLE, RST_WAIT, CKE_WAIT, XPR_WAIT, MRS, MRS_WAIT,
    ZQ, ZQ_WAIT, READY, REF, REF_WAIT
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   tcnt, tcnt_nx;
  logic [RW-1:0]   rank, rank_nx;
  logic [1:0]      mr, mr_nx;          // 0..3 -> MR2, MR3, MR1, MR0
  logic            rst_n_q, cke_q, done_q;
  logic            set_rst, set_cke, ref_grant;
  logic [CW-1:0]   ref_cnt;
  logic            ref_tick;
  logic [3:0]      pending;
  logic [RANKS-1:0] rank_sel_n;

  assign rank_sel_n = ~(RANKS'(1) << rank);
  assign ref_tick   = done_q && (ref_cnt == REFI_END);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= PWR_IDLE;
      tcnt    <= '0;
      rank    <= '0;
      mr      <= '0;
      rst_n_q <= 1'b0;
      cke_q   <= 1'b0;
      done_q  <= 1'b0;
      ref_cnt <= '0;
      pending <= '0;
    end else begin
      state   <= state_nx;
      tcnt    <= tcnt_nx;
      rank    <= rank_nx;
      mr      <= mr_nx;
      rst_n_q <= rst_n_q | set_rst;
      cke_q   <= cke_q | set_cke;
      done_q  <= done_q | (state_nx == READY);
      // Interval counter free-runs from the first cycle after READY is reached,
      // including while a refresh is in flight.
      if (done_q) begin
        ref_cnt <= (ref_cnt == REFI_END) ? '0 : ref_cnt + 1'b1;
      end
      // A tick and a grant in the same cycle cancel out.
      case ({ref_tick, ref_grant})
        2'b10:   if (pending != 4'd8) pending <= pending + 4'd1;
        2'b01:   pending <= pending - 4'd1;
        default: pending <= pending;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    tcnt_nx   = tcnt + 1'b1;
    rank_nx   = rank;
    mr_nx     = mr;
    set_rst   = 1'b0;
    set_cke   = 1'b0;
    ref_grant = 1'b0;
    cs_n      = '1;
    cmd       = CMD_NOP;
    ba        = 3'd0;
    addr      = 16'h0000;
    busy      = 1'b1;

    case (state)
      PWR_IDLE: begin
        busy    = 1'b0;
        tcnt_nx = '0;
        if (start) state_nx = RST_WAIT;
      end
      RST_WAIT: begin
        if (tcnt == RESET_END) begin
          state_nx = CKE_WAIT;
          tcnt_nx  = '0;
          set_rst  = 1'b1;
        end
      end
      CKE_WAIT: begin
        if (tcnt == CKE_END) begin
          state_nx = XPR_WAIT;
          tcnt_nx  = '0;
          set_cke  = 1'b1;
        end
      end
      XPR_WAIT: begin
        if (tcnt == XPR_END) begin
          state_nx = MRS;
          tcnt_nx  = '0;
          rank_nx  = '0;
          mr_nx    = 2'd0;
        end
      end
      // The MRS cycle itself is count 0 of the spacing window, so the next
      // command lands exactly T_MRD (or T_MOD after MR0) cycles later.
      MRS, MRS_WAIT: begin
        if (state == MRS) begin
          cs_n = rank_sel_n;
          cmd  = CMD_MRS;
          case (mr)
            2'd0:    begin ba = 3'd2; addr = MR2_VAL; end
            2'd1:    begin ba = 3'd3; addr = MR3_VAL; end
            2'd2:    begin ba = 3'd1; addr = MR1_VAL; end
            default: begin ba = 3'd0; addr = MR0_VAL | 16'h0100; end  // DLL reset
          endcase
          state_nx = MRS_WAIT;
        end
        if (mr != 2'd3) begin
          if (tcnt == MRD_END) begin
            state_nx = MRS;
            mr_nx    = mr + 2'd1;
            tcnt_nx  = '0;
          end
        end else if (tcnt == MOD_END) begin
          tcnt_nx = '0;
`ifdef DDR3_INIT_SEQ_ZQ_EN
          state_nx = ZQ;
`else
          if (rank == LAST_RANK) begin
            state_nx = READY;
          end else begin
            state_nx = MRS;
            rank_nx  = rank + 1'b1;
            mr_nx    = 2'd0;
          end
`endif
        end
      end
`ifdef DDR3_INIT_SEQ_ZQ_EN
      ZQ, ZQ_WAIT: begin
        if (state == ZQ) begin
          cs_n     = rank_sel_n;
          cmd      = CMD_ZQ;
          addr     = 16'h0400;   // A10=1 selects ZQCL (long calibration)
          state_nx = ZQ_WAIT;
        end
        if (tcnt == ZQI_END) begin
          tcnt_nx = '0;
          if (rank == LAST_RANK) begin
            state_nx = READY;
          end else begin
            state_nx = MRS;
            rank_nx  = rank + 1'b1;
            mr_nx    = 2'd0;
          end
        end
      end
`endif
      READY: begin
        busy    = 1'b0;
        tcnt_nx = '0;
        if (ref_ack && (pending != 4'd0)) begin
          state_nx  = REF;
          ref_grant = 1'b1;
        end
      end
      // REF occupies count 0, so the bus is held for T_RFC cycles in total.
      REF, REF_WAIT: begin
        if (state == REF) begin
          cs_n     = '0;
          cmd      = CMD_REF;
          state_nx = REF_WAIT;
        end
        if (tcnt == RFC_END) begin
          state_nx = READY;
          tcnt_nx  = '0;
        end
      end
      default: begin
        state_nx = PWR_IDLE;
        tcnt_nx  = '0;
        busy     = 1'b0;
      end
    endcase
  end

  assign rst_n      = rst_n_q;
  assign cke        = cke_q;
  assign done       = done_q;
  assign ref_req    = (pending != 4'd0);
  assign ref_urgent = (pending == 4'd8);

endmodule

// File: doc/ddr3_init_seq.md
DDR3_INIT_SEQ -- requirements
Module: ddr3_init_seq

Interface
REQ-001 Parameter RANKS, default 1, number of chip-selects, range 1..4.
REQ-002 Parameters T_RESET=200, T_CKE=500, T_XPR=120, T_MRD=4, T_MOD=12, T_ZQINIT=512, T_REFI=7800, T_RFC=110: clock-cycle counts, each at least 1.
REQ-003 Parameters MR0_VAL, MR1_VAL, MR2_VAL, MR3_VAL, default 16'h0000, 16-bit mode register contents.
REQ-004 clock  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins the power-up sequence.
REQ-007 ref_ack  in  1  controller grants a refresh slot.
REQ-008 rst_n  out  1  DRAM RESET#.
REQ-009 cke  out  1  DRAM CKE.
REQ-010 cs_n  out  RANKS  per-rank chip select, active low.
REQ-011 cmd  out  3  {ras_n,cas_n,we_n}.
REQ-012 ba  out  3  bank address.
REQ-013 addr  out  16  address bus.
REQ-014 busy  out  1  sequencer owns the command bus.
REQ-015 done  out  1  initialisation complete; stays high until reset.
REQ-016 ref_req  out  1  at least one refresh is pending.
REQ-017 ref_urgent  out  1  8 refreshes are pending.

Function
REQ-018 States: PWR_IDLE, RST_WAIT, CKE_WAIT, XPR_WAIT, MRS, MRS_WAIT, ZQ, ZQ_WAIT, READY, REF, REF_WAIT.
REQ-019 Command encodings are NOP=cs_n all 1 with cmd=3'b111; MRS=cmd 3'b000; REF=3'b001; ZQCL=3'b110 with addr[10]=1.
REQ-020 Each command is driven for exactly one cycle; NOP is driven in every other cycle.
REQ-021 In PWR_IDLE, start moves the block to RST_WAIT and asserts busy; start is ignored in every other state.
REQ-022 RST_WAIT holds rst_n=0 for T_RESET cycles, then sets rst_n=1 and enters CKE_WAIT.
REQ-023 CKE_WAIT holds cke=0 for T_CKE cycles, then sets cke=1 and enters XPR_WAIT.
REQ-024 XPR_WAIT lasts T_XPR cycles, then the block enters MRS for rank 0.
REQ-025 Per rank, MRS writes MR2, MR3, MR1 and MR0 in that order, with ba=2, 3, 1 and 0 and addr=MRx_VAL.
REQ-026 Only the current rank's cs_n bit is driven low.
REQ-027 During MR0, addr[8] (DLL reset) is forced to 1.
REQ-028 Successive MRS commands issue exactly T_MRD cycles apart.
REQ-029 ZQCL issues T_MOD cycles after MR0.
REQ-030 After ZQ_WAIT (T_ZQINIT cycles), the block advances to the next rank's MRS; after the last rank it enters READY.
REQ-031 READY sets done=1 and busy=0.
REQ-032 A refresh interval counter starts on entry to READY; each time it reaches T_REFI it wraps to 0 and increments a pending count.
REQ-033 The pending count is 4 bits and saturates at 8; ref_req = pending!=0; ref_urgent = pending==8.
REQ-034 In READY, ref_ack with pending!=0 moves the block to REF.
REQ-035 REF issues one REF command to all ranks (all cs_n=0), decrements pending, and asserts busy.
REQ-036 REF_WAIT lasts T_RFC cycles, then returns to READY and drops busy.
REQ-037 ref_ack while pending==0 or outside READY is ignored.
REQ-038 A T_REFI tick and a REF decrement in the same cycle leave pending unchanged.
REQ-039 The interval counter keeps running during REF_WAIT.
REQ-040 Timing counters are $clog2(max parameter + 1) bits wide.

Reset
REQ-041 reset in any state, including mid-sequence, forces PWR_IDLE on the next edge.
REQ-042 Reset values: rst_n=0, cke=0, cs_n all 1, cmd=3'b111, ba=0, addr=0, busy=0, done=0, ref_req=0, ref_urgent=0, counters and pending=0.

Configuration
REQ-043 With DDR3_INIT_SEQ_ZQ_EN defined, ZQ and ZQ_WAIT execute per rank as specified.
REQ-044 Without DDR3_INIT_SEQ_ZQ_EN, ZQ and ZQ_WAIT are removed, and the next rank, or READY, follows T_MOD cycles after MR0.

Verification
REQ-045 Scenario 1 (RANKS=1, T_RESET=4, T_CKE=5, T_XPR=3, T_MRD=4, T_MOD=6, T_ZQINIT=8, ZQ enabled): pulse start. Required response: rst_n rises 4 cycles later; cke rises 5 cycles after that; MRS ba=2,3,1,0 spaced 4 cycles; ZQCL 6 cycles after MR0; done 8 cycles after ZQCL.
REQ-046 Scenario 2 (MR0_VAL=16'h0520): the MR0 command shows addr=16'h0520 and ba=0; with MR0_VAL=16'h0420, addr reads 16'h0520.
REQ-047 Scenario 3 (RANKS=2): the full MRS and ZQ set issues with cs_n=2'b10, then repeats with cs_n=2'b01; done follows the second rank.
REQ-048 Scenario 4 (T_REFI=20, T_RFC=5, no ref_ack for 200 cycles): ref_urgent=1 with pending=8; one ref_ack gives a single REF with cs_n all 0, busy for 5 cycles, and pending=7.
REQ-049 Scenario 5: reset asserted at cycle 3 of MRS_WAIT gives PWR_IDLE and all REQ-042 values; a second start replays Scenario 1 timing exactly.
REQ-050 Scenario 6: start pulsed during CKE_WAIT and ref_ack pulsed with pending=0 both produce no change in state or outputs.
